// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared encodings for the data-SRAM arbiter.
//   - access size encodings (SIZE_BYTE / SIZE_HALF / SIZE_WORD, 2'b11 reserved)
//   - FSM state encoding (2 bits)
//   - req_t: the request fields latched at grant time
package sram_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_MERGE  = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundle of both requester ports plus the Memory data port.
//   mN_req/we/size/addr/wdata : requester -> arbiter
//   mN_gnt/done/err, rdata     : arbiter -> requester
//   sram_addr/w_sram/w_sram_en : arbiter -> Memory
//   r_sram                     : Memory -> arbiter (combinational read word)
// Modports: slave = arbiter side, master = requesters + memory side.
interface sram_arbiter_if;
  logic        m0_req, m0_we, m0_gnt, m0_done, m0_err;
  logic [1:0]  m0_size;
  logic [31:0] m0_addr, m0_wdata;
  logic        m1_req, m1_we, m1_gnt, m1_done, m1_err;
  logic [1:0]  m1_size;
  logic [31:0] m1_addr, m1_wdata;
  logic [31:0] rdata;
  logic [31:0] sram_addr, w_sram, r_sram;
  logic        w_sram_en;

  modport slave (
    input  m0_req, m0_we, m0_size, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_size, m1_addr, m1_wdata,
    input  r_sram,
    output m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err,
    output rdata, sram_addr, w_sram, w_sram_en
  );

  modport master (
    output m0_req, m0_we, m0_size, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_size, m1_addr, m1_wdata,
    output r_sram,
    input  m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err,
    input  rdata, sram_addr, w_sram, w_sram_en
  );
endinterface

// File: rtl/sram_byte_lane.sv
// sram_byte_lane: combinational lane logic for sub-word accesses.
//   word_i    : memory word (read data or merge register)
//   wdata_i   : right-aligned store data
//   addr_lo_i : byte offset within the word
//   size_i    : access size
//   load_o    : addressed lane(s) of word_i, zero-extended
//   merge_o   : word_i with the addressed lane(s) replaced by wdata_i
//   misalign_o: reserved size or misaligned halfword/word
// Little-endian: byte k lives in bits [8k+7:8k].
module sram_byte_lane
  import sram_arbiter_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o,
  output logic        misalign_o
);

  logic [4:0] byte_sh;
  logic [4:0] half_sh;

  assign byte_sh = {addr_lo_i, 3'b000};
  assign half_sh = {addr_lo_i[1], 4'b0000};

  always_comb begin
    load_o  = word_i;
    merge_o = wdata_i;
    case (size_i)
      SIZE_BYTE: begin
        load_o                = {24'h0, word_i[byte_sh +: 8]};
        merge_o               = word_i;
        merge_o[byte_sh +: 8] = wdata_i[7:0];
      end
      SIZE_HALF: begin
        load_o                 = {16'h0, word_i[half_sh +: 16]};
        merge_o                = word_i;
        merge_o[half_sh +: 16] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

  assign misalign_o = (size_i == 2'b11) ||
                      (size_i == SIZE_HALF && addr_lo_i[0]) ||
                      (size_i == SIZE_WORD && addr_lo_i != 2'b00);

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-master arbiter for the word-only data-SRAM port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sram_arbiter_if.slave (requester handshakes + Memory port)
// Sub-word stores use read-modify-write (ACCESS reads, MERGE writes).
// Misaligned / reserved-size requests go straight from IDLE to DONE with err.
// Config macro SRAM_ARB_RR_EN: round-robin on contention (last-owner
// register resets to m1); otherwise fixed priority, m0 first.
module sram_arbiter
  import sram_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  bus
);

  state_e      state_q, state_d;
  req_t        cur_q, win_req;
  logic        owner_q, err_q;
  logic [31:0] rdata_q, merge_q;
  logic        win_any, win_sel;

  logic [1:0]  gnt, done, err;
  logic [31:0] sram_addr, w_sram;
  logic        w_sram_en;

  logic [31:0] ln_word, ln_load, ln_merge;
  logic [1:0]  ln_addr_lo, ln_size;
  logic        ln_misalign;

`ifdef SRAM_ARB_RR_EN
  logic last_q;
`endif

  // Winner selection; win_sel = 1 means m1.
  always_comb begin
    win_any = bus.m0_req | bus.m1_req;
`ifdef SRAM_ARB_RR_EN
    win_sel = (bus.m0_req & bus.m1_req) ? ~last_q : ~bus.m0_req;
`else
    win_sel = ~bus.m0_req;
`endif
    win_req.we    = win_sel ? bus.m1_we    : bus.m0_we;
    win_req.size  = win_sel ? bus.m1_size  : bus.m0_size;
    win_req.addr  = win_sel ? bus.m1_addr  : bus.m0_addr;
    win_req.wdata = win_sel ? bus.m1_wdata : bus.m0_wdata;
  end

  // One lane instance serves both phases: in IDLE it looks at the incoming
  // winner (for the error check), afterwards at the latched request.
  assign ln_size    = (state_q == ST_IDLE)  ? win_req.size       : cur_q.size;
  assign ln_addr_lo = (state_q == ST_IDLE)  ? win_req.addr[1:0]  : cur_q.addr[1:0];
  assign ln_word    = (state_q == ST_MERGE) ? merge_q            : bus.r_sram;

  sram_byte_lane u_lane (
    .word_i     (ln_word),
    .wdata_i    (cur_q.wdata),
    .addr_lo_i  (ln_addr_lo),
    .size_i     (ln_size),
    .load_o     (ln_load),
    .merge_o    (ln_merge),
    .misalign_o (ln_misalign)
  );

  always_comb begin
    state_d   = state_q;
    gnt       = 2'b00;
    done      = 2'b00;
    err       = 2'b00;
    sram_addr = 32'h0;
    w_sram    = 32'h0;
    w_sram_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          gnt[win_sel] = 1'b1;
          state_d      = ln_misalign ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        sram_addr = {cur_q.addr[31:2], 2'b00};
        if (cur_q.we && cur_q.size == SIZE_WORD) begin
          w_sram    = cur_q.wdata;
          w_sram_en = 1'b1;
          state_d   = ST_DONE;
        end else if (cur_q.we) begin
          state_d = ST_MERGE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_MERGE: begin
        sram_addr = {cur_q.addr[31:2], 2'b00};
        w_sram    = ln_merge;
        w_sram_en = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        done[owner_q] = 1'b1;
        err[owner_q]  = err_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      merge_q <= 32'h0;
`ifdef SRAM_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (win_any) begin
            cur_q   <= win_req;
            owner_q <= win_sel;
            err_q   <= ln_misalign;
            rdata_q <= 32'h0;   // errors and stores complete with rdata = 0
`ifdef SRAM_ARB_RR_EN
            last_q  <= win_sel;
`endif
          end
        end
        ST_ACCESS: begin
          if (!cur_q.we)
            rdata_q <= ln_load;
          else if (cur_q.size != SIZE_WORD)
            merge_q <= bus.r_sram;
        end
        default: ;
      endcase
    end
  end

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_done   = done[0];
  assign bus.m1_done   = done[1];
  assign bus.m0_err    = err[0];
  assign bus.m1_err    = err[1];
  assign bus.rdata     = rdata_q;
  assign bus.sram_addr = sram_addr;
  assign bus.w_sram    = w_sram;
  assign bus.w_sram_en = w_sram_en;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized + directed bench for sram_arbiter with a
// transaction-level reference model (byte-array memory, latency table,
// arbitration rule) checked against the DUT every cycle.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if bus();

  sram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [1:0]  req = 2'b00;
  logic        f_we [2];
  logic [1:0]  f_sz [2];
  logic [31:0] f_a  [2];
  logic [31:0] f_wd [2];

  assign bus.m0_req = req[0];   assign bus.m1_req = req[1];
  assign bus.m0_we  = f_we[0];  assign bus.m1_we  = f_we[1];
  assign bus.m0_size = f_sz[0]; assign bus.m1_size = f_sz[1];
  assign bus.m0_addr = f_a[0];  assign bus.m1_addr = f_a[1];
  assign bus.m0_wdata = f_wd[0]; assign bus.m1_wdata = f_wd[1];

  // Physical memory seen by the DUT (64 words, indexed by addr[7:2]).
  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  assign bus.r_sram = mem[bus.sram_addr[7:2]];
  always @(posedge clk) if (bus.w_sram_en === 1'b1) mem[bus.sram_addr[7:2]] <= bus.w_sram;

  wire [1:0] gnt  = {bus.m1_gnt, bus.m0_gnt};
  wire [1:0] done = {bus.m1_done, bus.m0_done};
  wire [1:0] err  = {bus.m1_err, bus.m0_err};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " gnt"}, {30'h0, gnt}, 32'h0);
    chk({tag, " done"}, {30'h0, done}, 32'h0);
    chk({tag, " err"}, {30'h0, err}, 32'h0);
    chk({tag, " rdata"}, bus.rdata, 32'h0);
    chk({tag, " sram_addr"}, bus.sram_addr, 32'h0);
    chk({tag, " w_sram"}, bus.w_sram, 32'h0);
    chk({tag, " w_sram_en"}, {31'h0, bus.w_sram_en}, 32'h0);
  endtask

  // ---------------- reference model / compare process ----------------
  int          m_cyc = 0, g_cyc = 0, m_lat = 0, m_wlat = 0, m_own = 0, m_last = 1, m_w = 0;
  int          m_nb, m_off, m_d;
  bit          busy = 1'b0;
  logic        e_err, e_we;
  logic [1:0]  m_sz, eg, ed, ee;
  logic        ew;
  logic [31:0] m_a, m_wd, e_rd, e_wd, e_wa, m_word;
  int          gq[$];

  initial begin
    forever begin
      @(negedge clk);
      m_cyc++;
      if (rst) begin
        busy   = 1'b0;
        m_last = 1;
      end else begin
        eg = 2'b00;
        if (!busy && req != 2'b00) begin
`ifdef SRAM_ARB_RR_EN
          if (req == 2'b11) m_w = (m_last == 1) ? 0 : 1;
          else              m_w = req[0] ? 0 : 1;
`else
          m_w = req[0] ? 0 : 1;
`endif
          eg = (m_w == 0) ? 2'b01 : 2'b10;
        end
        chk("gnt", {30'h0, gnt}, {30'h0, eg});

        ed = 2'b00; ee = 2'b00; ew = 1'b0; m_d = m_cyc - g_cyc;
        if (busy) begin
          if (m_d == m_lat) begin
            ed[m_own] = 1'b1;
            ee[m_own] = e_err;
          end
          if (!e_err && e_we && m_d == m_wlat) ew = 1'b1;
        end
        chk("done", {30'h0, done}, {30'h0, ed});
        chk("err", {30'h0, err}, {30'h0, ee});
        chk("w_sram_en", {31'h0, bus.w_sram_en}, {31'h0, ew});
        if (ew) begin
          chk("w_sram", bus.w_sram, e_wd);
          chk("write addr", bus.sram_addr, e_wa);
          ref_mem[e_wa[7:2]] = e_wd;
        end
        if (busy && m_d == 1 && !e_err) chk("access addr", bus.sram_addr, e_wa);
        if (ed != 2'b00 && (!e_we || e_err)) chk("rdata", bus.rdata, e_rd);
        if (busy && m_d == m_lat) busy = 1'b0;

        if (eg != 2'b00) begin
          gq.push_back(m_w);
          m_last = m_w; m_own = m_w; busy = 1'b1; g_cyc = m_cyc;
          e_we = f_we[m_w]; m_sz = f_sz[m_w]; m_a = f_a[m_w]; m_wd = f_wd[m_w];
          e_err = (m_sz == 2'd3) || (m_sz == 2'd1 && m_a[0]) || (m_sz == 2'd2 && m_a[1:0] != 2'd0);
          e_wa = {m_a[31:2], 2'b00};
          e_rd = 32'h0; e_wd = 32'h0;
          if (e_err)                     m_lat = 1;
          else if (e_we && m_sz != 2'd2) m_lat = 3;
          else                           m_lat = 2;
          m_wlat = (m_sz == 2'd2) ? 1 : 2;
          if (!e_err) begin
            m_word = ref_mem[m_a[7:2]];
            m_nb   = 1 << m_sz;
            m_off  = int'(m_a[1:0]);
            for (int i = 0; i < m_nb; i++) begin
              if (e_we) m_word[8*(m_off+i) +: 8] = m_wd[8*i +: 8];
              else      e_rd[8*i +: 8] = m_word[8*(m_off+i) +: 8];
            end
            e_wd = m_word;
          end
        end
      end
    end
  end

  // ---------------- requester driver ----------------
  // Called at posedge+1. wt = IDLE cycles waited before gnt, lt = gnt->done.
  task automatic xact(input int m, input logic we, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input bit hold,
                      output int wt, output int lt, output logic [31:0] rd,
                      output logic er, output logic [31:0] wdat,
                      output logic [31:0] wadr, output bit wn);
    bit got;
    got = 1'b0; wt = 0; lt = 0; rd = '0; er = 1'b0; wdat = '0; wadr = '0; wn = 1'b0;
    f_we[m] = we; f_sz[m] = sz; f_a[m] = a; f_wd[m] = wd; req[m] = 1'b1;
    while (!got && wt < 60) begin
      @(negedge clk);
      if (gnt[m]) got = 1'b1;
      else begin @(posedge clk); #1; wt++; end
    end
    chk($sformatf("m%0d gnt seen", m), {31'h0, got}, 32'h1);
    if (!got) begin req[m] = 1'b0; return; end
    @(posedge clk); #1;
    if (!hold) req[m] = 1'b0;
    got = 1'b0;
    while (!got && lt < 8) begin
      @(negedge clk); lt++;
      if (bus.w_sram_en) begin wn = 1'b1; wdat = bus.w_sram; wadr = bus.sram_addr; end
      if (done[m]) begin got = 1'b1; rd = bus.rdata; er = err[m]; end
      else begin @(posedge clk); #1; end
    end
    chk($sformatf("m%0d done seen", m), {31'h0, got}, 32'h1);
    @(posedge clk); #1;
  endtask

  int wt, lt; logic [31:0] rd, wdat, wadr; logic er; bit wn;

  initial begin
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    for (int i = 0; i < 2; i++) begin f_we[i] = 0; f_sz[i] = 0; f_a[i] = 0; f_wd[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;

    // word store then load, m0
    xact(0, 1, SIZE_WORD, 32'h10, 32'hDEADBEEF, 0, wt, lt, rd, er, wdat, wadr, wn);
    chk("t1 st w_sram", wdat, 32'hDEADBEEF);
    chk("t1 st addr", wadr, 32'h10);
    chk("t1 st wen", {31'h0, wn}, 32'h1);
    chk("t1 st lat", lt, 2);
    xact(0, 0, SIZE_WORD, 32'h10, 32'h0, 0, wt, lt, rd, er, wdat, wadr, wn);
    chk("t1 ld rdata", rd, 32'hDEADBEEF);
    chk("t1 ld err", {31'h0, er}, 32'h0);
    chk("t1 ld lat", lt, 2);

    // byte store via RMW
    xact(0, 1, SIZE_WORD, 32'h20, 32'h11223344, 0, wt, lt, rd, er, wdat, wadr, wn);
    xact(1, 1, SIZE_BYTE, 32'h22, 32'h000000AA, 0, wt, lt, rd, er, wdat, wadr, wn);
    chk("t2 merge w_sram", wdat, 32'h11AA3344);
    chk("t2 merge addr", wadr, 32'h20);
    chk("t2 lat", lt, 3);
    xact(1, 0, SIZE_BYTE, 32'h22, 32'h0, 0, wt, lt, rd, er, wdat, wadr, wn);
    chk("t2 byte load", rd, 32'h000000AA);

    // misaligned
    xact(0, 0, SIZE_HALF, 32'h21, 32'h0, 0, wt, lt, rd, er, wdat, wadr, wn);
    chk("t3 half err", {31'h0, er}, 32'h1);
    chk("t3 half lat", lt, 1);
    chk("t3 half wen", {31'h0, wn}, 32'h0);
    chk("t3 half rdata", rd, 32'h0);
    xact(0, 1, SIZE_WORD, 32'h22, 32'hCAFEF00D, 0, wt, lt, rd, er, wdat, wadr, wn);
    chk("t3 word err", {31'h0, er}, 32'h1);
    chk("t3 word wen", {31'h0, wn}, 32'h0);
    xact(0, 0, SIZE_WORD, 32'h20, 32'h0, 0, wt, lt, rd, er, wdat, wadr, wn);
    chk("t3 mem unchanged", rd, 32'h11AA3344);

    // reset during ACCESS of a byte store
    f_we[1] = 1; f_sz[1] = SIZE_BYTE; f_a[1] = 32'h23; f_wd[1] = 32'h55; req[1] = 1'b1;
    @(negedge clk);
    chk("t4 gnt", {30'h0, gnt}, 32'h2);
    @(posedge clk); #1 req[1] = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t4 no done in access", {30'h0, done}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_idle("t4 after reset");
    @(posedge clk); #1;
    xact(1, 0, SIZE_WORD, 32'h20, 32'h0, 0, wt, lt, rd, er, wdat, wadr, wn);
    chk("t4 post rdata", rd, 32'h11AA3344);
    chk("t4 post lat", lt, 2);

    // back-to-back on m1
    xact(1, 0, SIZE_WORD, 32'h10, 32'h0, 1, wt, lt, rd, er, wdat, wadr, wn);
    xact(1, 0, SIZE_BYTE, 32'h13, 32'h0, 0, wt, lt, rd, er, wdat, wadr, wn);
    chk("t5 b2b wait", wt, 0);
    chk("t5 b2b rdata", rd, 32'h000000DE);

    // contention
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    gq.delete();
    fork
      begin
        int a0, b0; logic [31:0] c0, d0, e0; logic f0; bit g0;
        for (int k = 0; k < 4; k++)
          xact(0, 0, SIZE_WORD, 32'h10, 32'h0, (k < 3), a0, b0, c0, f0, d0, e0, g0);
      end
      begin
        int a1, b1; logic [31:0] c1, d1, e1; logic f1; bit g1;
        for (int k = 0; k < 2; k++)
          xact(1, 0, SIZE_WORD, 32'h20, 32'h0, (k < 1), a1, b1, c1, f1, d1, e1, g1);
      end
    join
    chk("t6 grant count", gq.size(), 6);
    if (gq.size() == 6) begin
`ifdef SRAM_ARB_RR_EN
      chk("t6 g0", gq[0], 0); chk("t6 g1", gq[1], 1); chk("t6 g2", gq[2], 0);
      chk("t6 g3", gq[3], 1); chk("t6 g4", gq[4], 0); chk("t6 g5", gq[5], 0);
`else
      chk("t6 g0", gq[0], 0); chk("t6 g1", gq[1], 0); chk("t6 g2", gq[2], 0);
      chk("t6 g3", gq[3], 0); chk("t6 g4", gq[4], 1); chk("t6 g5", gq[5], 1);
`endif
    end

    // randomized traffic from both masters
    fork
      for (int mm = 0; mm < 2; mm++) begin
        fork
          automatic int m = mm;
          begin
            int a2, b2; logic [31:0] c2, d2, e2; logic f2; bit g2;
            logic [1:0] sz; logic [31:0] ad; int r;
            for (int k = 0; k < 60; k++) begin
              repeat ($urandom_range(1, 3)) @(posedge clk);
              #1;
              r  = $urandom_range(0, 9);
              sz = (r < 3) ? SIZE_BYTE : (r < 6) ? SIZE_HALF : (r < 9) ? SIZE_WORD : 2'b11;
              ad = $urandom_range(0, 255);
              if ($urandom_range(0, 3) == 0) ad[31:8] = 24'($urandom);
              if ($urandom_range(0, 9) < 7 && sz != 2'b11) begin
                if (sz == SIZE_HALF) ad[0] = 1'b0;
                if (sz == SIZE_WORD) ad[1:0] = 2'b00;
              end
              xact(m, 1'($urandom_range(0, 1)), sz, ad, $urandom, 0, a2, b2, c2, f2, d2, e2, g2);
            end
          end
        join_none
      end
    join
    wait fork;

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
